halt_dump_monitor: RTL and testbench

HALT_DUMP_MONITOR -- requirements
Module: halt_dump_monitor

---
 rtl/halt_dump_monitor.sv | 155 +++++++++++++++
 tb/tb_halt_dump_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/halt_dump_monitor.sv
// Halt dump monitor: counts cycles until the CPU halts (or a cycle limit is
// reached), then streams a cycle-count record, DUMP_COUNT register records
// read from the register file, and an end marker over a valid/ready link.
module halt_dump_monitor #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DUMP_COUNT = 10,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic              is_halt_N,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  clk_cnt,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [2:0] {
    RUN, EMIT_CNT, RD_REQ, RD_WAIT, EMIT_REG, EMIT_END, DONE
  } state_t;

  localparam logic [1:0]        KIND_CNT = 2'd0;
  localparam logic [1:0]        KIND_REG = 2'd1;
  localparam logic [1:0]        KIND_END = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_COUNT - 1);
  localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  TO_PRE   = CNT_W'(TIMEOUT - 1);
  localparam bit                TO_EN    = (TIMEOUT != 0);

  state_t            state;
  logic              halt_prev;
  logic [ADDR_W-1:0] idx;
  logic              halt_evt;
  logic              to_hit;
  logic              handshake;

  assign halt_evt  = halt_prev & ~is_halt_N;
  assign to_hit    = TO_EN && (clk_cnt == TO_PRE);
  assign handshake = out_valid & out_ready;

  // Previous halt level for falling-edge detection; starts high so a halt
  // that is already asserted at reset release is seen on the first edge.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples the pre-edge values, independent of block ordering.
    if (RST) halt_prev <= 1'b1;
    else     halt_prev <= is_halt_N;
  end

  // Dump sequencer with registered stream and register-file outputs.
  // out_data doubles as the hold register for the register read data.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state     <= RUN;
      clk_cnt   <= '0;
      idx       <= '0;
      timeout   <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      reg_rd_en <= 1'b0;
      reg_addr  <= '0;
      out_kind  <= KIND_CNT;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      // NOTE: signals not assigned in a branch simply keep their register
      // value; inside always_ff this is a hold, never an inferred latch.
      case (state)
        RUN: begin
          if (halt_evt) begin
            state     <= EMIT_CNT;
            out_valid <= 1'b1;
            out_kind  <= KIND_CNT;
            out_index <= '0;
            out_data  <= DATA_W'(clk_cnt);
          end else if (to_hit) begin
            clk_cnt   <= TO_LIMIT;
            timeout   <= 1'b1;
            state     <= EMIT_CNT;
            out_valid <= 1'b1;
            out_kind  <= KIND_CNT;
            out_index <= '0;
            out_data  <= DATA_W'(TO_LIMIT);
          end else if (clk_cnt != '1) begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        EMIT_CNT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            idx       <= '0;
            reg_rd_en <= 1'b1;
            reg_addr  <= '0;
            state     <= RD_REQ;
          end
        end

        RD_REQ: begin
          reg_rd_en <= 1'b0;
          state     <= RD_WAIT;
        end

        RD_WAIT: begin
          out_data  <= reg_data;
          out_valid <= 1'b1;
          out_kind  <= KIND_REG;
          out_index <= idx;
          state     <= EMIT_REG;
        end

        EMIT_REG: begin
          if (handshake) begin
            if (idx == LAST_IDX) begin
              out_kind  <= KIND_END;
              out_index <= '0;
              out_data  <= DATA_W'(timeout);
              state     <= EMIT_END;
            end else begin
              out_valid <= 1'b0;
              idx       <= idx + ADDR_W'(1);
              reg_rd_en <= 1'b1;
              reg_addr  <= idx + ADDR_W'(1);
              state     <= RD_REQ;
            end
          end
        end

        EMIT_END: begin
          if (handshake) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // Parked until reset.
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_halt_dump_monitor.sv
// Bench for halt_dump_monitor: two instances share stimulus, one with the
// cycle limit disabled and one with a limit of 50. Received records are
// collected per instance and compared with an expected dump derived from
// the halt time, the cycle limit and the register file contents.
module tb_halt_dump_monitor;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int DUMP_COUNT = 10;
  localparam int CNT_W      = 32;
  localparam int TO1        = 50;
  localparam int NREC       = DUMP_COUNT + 2;

  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] data;
  } rec_t;

  typedef struct {
    int halt_edge;
    int rdy_pct;
    int cnt0;
    int to0;
    int cnt1;
    int to1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic is_halt_n = 1'b1;
  logic out_ready = 1'b1;

  logic              rd_en0, rd_en1, valid0, valid1, done0, done1, to0, to1;
  logic [ADDR_W-1:0] addr0, addr1, index0, index1;
  logic [DATA_W-1:0] rdata0, rdata1, data0, data1;
  logic [1:0]        kind0, kind1;
  logic [CNT_W-1:0]  cnt0, cnt1;

  logic [DATA_W-1:0] regs [1 << ADDR_W];
  rec_t              q0[$], q1[$];
  int                n_checks = 0;
  int                n_pass = 0;
  int                cyc = 0;
  int                halt_at = 1000;

  always #5 clk = ~clk;

  halt_dump_monitor u_dut0 (
    .CLOCK_50(clk), .RST(rst), .is_halt_N(is_halt_n),
    .reg_rd_en(rd_en0), .reg_addr(addr0), .reg_data(rdata0),
    .out_valid(valid0), .out_ready(out_ready), .out_kind(kind0),
    .out_index(index0), .out_data(data0), .clk_cnt(cnt0),
    .done(done0), .timeout(to0)
  );

  halt_dump_monitor #(.TIMEOUT(TO1)) u_dut1 (
    .CLOCK_50(clk), .RST(rst), .is_halt_N(is_halt_n),
    .reg_rd_en(rd_en1), .reg_addr(addr1), .reg_data(rdata1),
    .out_valid(valid1), .out_ready(out_ready), .out_kind(kind1),
    .out_index(index1), .out_data(data1), .clk_cnt(cnt1),
    .done(done1), .timeout(to1)
  );

  // Register files with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en0) rdata0 <= regs[addr0];
    if (rd_en1) rdata1 <= regs[addr1];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Stream monitor: collect accepted records, and require a stalled record
  // to stay valid and unchanged until accepted.
  rec_t pk0, pk1, held0, held1;
  logic pend0 = 1'b0, pend1 = 1'b0;
  assign pk0 = '{kind: kind0, index: index0, data: data0};
  assign pk1 = '{kind: kind1, index: index1, data: data1};

  always @(negedge clk) begin
    if (rst) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (pend0) check("hold0", {valid0, pk0}, {1'b1, held0});
      if (pend1) check("hold1", {valid1, pk1}, {1'b1, held1});
      if (valid0 && out_ready) q0.push_back(pk0);
      if (valid1 && out_ready) q1.push_back(pk1);
      pend0 <= valid0 && !out_ready;
      pend1 <= valid1 && !out_ready;
      held0 <= pk0;
      held1 <= pk1;
    end
  end

  // Reference: a halt sampled at edge h (counted from reset release) beats a
  // limit reached at edge T; otherwise the limit fires first.
  function automatic void ref_cnt(input int h, input int lim, output int c, output int t);
    if (lim != 0 && h > lim) begin
      c = lim;
      t = 1;
    end else begin
      c = h - 1;
      t = 0;
    end
  endfunction

  function automatic rec_t exp_rec(input int i, input int c, input int t);
    rec_t r;
    if (i == 0) begin
      r.kind = 2'd0; r.index = '0; r.data = DATA_W'(c);
    end else if (i <= DUMP_COUNT) begin
      r.kind = 2'd1; r.index = ADDR_W'(i - 1); r.data = regs[i - 1];
    end else begin
      r.kind = 2'd2; r.index = '0; r.data = DATA_W'(t);
    end
    return r;
  endfunction

  task automatic start_dump(input int h);
    halt_at   = h;
    rst       = 1'b1;
    is_halt_n = (h <= 1) ? 1'b0 : 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    q0.delete();
    q1.delete();
  endtask

  task automatic step(input bit rdy);
    is_halt_n = (cyc + 1 >= halt_at) ? 1'b0 : 1'b1;
    out_ready = rdy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to_done(input int pct);
    int guard = 0;
    while (!(done0 && done1) && guard < 1000) begin
      step($urandom_range(99) < pct);
      guard++;
    end
    check("done_within_bound", {done0, done1}, 2'b11);
  endtask

  task automatic compare_dump(input string tag, input int c0, input int t0, input int c1, input int t1);
    check($sformatf("%s_nrec0", tag), q0.size(), NREC);
    check($sformatf("%s_nrec1", tag), q1.size(), NREC);
    for (int i = 0; i < NREC && i < q0.size(); i++)
      check($sformatf("%s_dut0_rec%0d", tag, i), q0[i], exp_rec(i, c0, t0));
    for (int i = 0; i < NREC && i < q1.size(); i++)
      check($sformatf("%s_dut1_rec%0d", tag, i), q1[i], exp_rec(i, c1, t1));
    repeat (3) step(1'b1);
    check($sformatf("%s_done_park", tag), {done0, done1, valid0, valid1, rd_en0, rd_en1}, 6'b110000);
    check($sformatf("%s_cnt0", tag), cnt0, c0);
    check($sformatf("%s_cnt1", tag), cnt1, c1);
    check($sformatf("%s_timeout", tag), {to0, to1}, {t0[0], t1[0]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   g;
    int   c0, t0, c1, t1;

    vecs[0] = '{halt_edge: 21, rdy_pct: 100, cnt0: 20, to0: 0, cnt1: 20, to1: 0};
    vecs[1] = '{halt_edge: 60, rdy_pct: 100, cnt0: 59, to0: 0, cnt1: 50, to1: 1};
    vecs[2] = '{halt_edge: 50, rdy_pct: 100, cnt0: 49, to0: 0, cnt1: 49, to1: 0};
    vecs[3] = '{halt_edge: 51, rdy_pct: 100, cnt0: 50, to0: 0, cnt1: 50, to1: 1};
    vecs[4] = '{halt_edge: 1,  rdy_pct: 100, cnt0: 0,  to0: 0, cnt1: 0,  to1: 0};
    vecs[5] = '{halt_edge: 2,  rdy_pct: 50,  cnt0: 1,  to0: 0, cnt1: 1,  to1: 0};

    for (int i = 0; i < (1 << ADDR_W); i++) regs[i] = DATA_W'(3 * i);

    // Reset state.
    start_dump(1000);
    check("rst_flags", {valid0, done0, to0, rd_en0, valid1, done1, to1, rd_en1}, 8'h00);
    check("rst_cnt", {cnt0, cnt1}, 64'd0);
    check("rst_payload", {kind0, index0, data0, addr0}, 64'd0);

    // Directed table.
    foreach (vecs[v]) begin
      start_dump(vecs[v].halt_edge);
      run_to_done(vecs[v].rdy_pct);
      compare_dump($sformatf("vec%0d", v), vecs[v].cnt0, vecs[v].to0, vecs[v].cnt1, vecs[v].to1);
    end

    // Back-pressure on the register record at index 3.
    start_dump(21);
    g = 0;
    while (!(valid0 && kind0 == 2'd1 && index0 == 5'd3) && g < 200) begin
      step(1'b1);
      g++;
    end
    check("stall_reach_idx3", g < 200, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0);
      check($sformatf("stall_c%0d", k), {valid0, kind0, index0, data0, rd_en0},
            {1'b1, 2'd1, 5'd3, 32'd9, 1'b0});
    end
    run_to_done(100);
    compare_dump("stall", 20, 0, 20, 0);

    // Reset pulse in the middle of a dump, then a fresh dump.
    start_dump(21);
    g = 0;
    while (!(valid0 && kind0 == 2'd1 && index0 == 5'd5) && g < 200) begin
      step(1'b1);
      g++;
    end
    check("mid_reach_idx5", g < 200, 1'b1);
    rst       = 1'b1;
    is_halt_n = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_flags", {valid0, done0, to0, rd_en0, valid1, done1}, 6'd0);
    check("mid_rst_cnt", {cnt0, cnt1}, 64'd0);
    halt_at = 30;
    cyc     = 0;
    q0.delete();
    q1.delete();
    repeat (3) step(1'b1);
    check("mid_rst_counting", {cnt0, cnt1}, {32'd3, 32'd3});
    run_to_done(100);
    compare_dump("redump", 29, 0, 29, 0);

    // Randomized dumps against the reference rule.
    for (int r = 0; r < 8; r++) begin
      int h, pct;
      for (int i = 0; i < (1 << ADDR_W); i++) regs[i] = $urandom;
      h   = $urandom_range(70, 1);
      pct = $urandom_range(100, 30);
      ref_cnt(h, 0, c0, t0);
      ref_cnt(h, TO1, c1, t1);
      start_dump(h);
      run_to_done(pct);
      compare_dump($sformatf("rand%0d", r), c0, t0, c1, t1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
